// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_pkg
//  Purpose  : Shared constants for the seven-segment scan controller.
//             A digit code is 5 bits: bit 4 = decimal point, [3:0] = value.
//  Revision : 1.0  initial release
// ============================================================================
package seg_scan_pkg;

  localparam int          CODE_W      = 5;
  localparam int          CODE_DP_BIT = 4;
  localparam logic [4:0]  CODE_BLANK  = 5'b01111;
  localparam logic [4:0]  CODE_ZERO   = 5'b00000;

endpackage : seg_scan_pkg
`default_nettype wire

// File: rtl/seg_scan_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_prescaler
//  Purpose  : Free-running divider; counts 0..TICK_DIV-1 and asserts tick
//             combinationally while the count sits at TICK_DIV-1.
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan_prescaler #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int               CNT_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_MAX);

  // Count up, wrapping to zero on the terminal count.
  always_ff @(posedge clk) begin
    if (rst || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule : seg_scan_prescaler
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl
//  Purpose  : Time-multiplexed scan controller for a multi-digit seven-segment
//             display. Frames are accepted into a pending buffer and promoted
//             to the active buffer only at a frame boundary (tear-free).
//             Optional build macro: SEG_SCAN_LZB_EN enables leading-zero
//             blanking, applied when a pending frame is promoted.
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int TICK_DIV = 100000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_valid,
  output logic                       frame_ready,
  input  logic [N_DIGITS*CODE_W-1:0] frame_data,
  output logic [CODE_W-1:0]          dig_code,
  output logic [N_DIGITS-1:0]        an_n,
  output logic                       frame_done
);

  localparam int                  IDX_W    = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] ONE_HOT0 = {{(N_DIGITS-1){1'b0}}, 1'b1};

  logic              tick;
  logic              last_slot;
  logic              boundary;
  logic              accept;
  logic              pending;
  logic [IDX_W-1:0]  idx;
  logic [CODE_W-1:0] frame_code  [N_DIGITS];
  logic [CODE_W-1:0] pending_buf [N_DIGITS];
  logic [CODE_W-1:0] active_buf  [N_DIGITS];
  logic [CODE_W-1:0] promote_buf [N_DIGITS];

  seg_scan_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Split the flat input frame into per-digit codes.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_unpack
    assign frame_code[g] = frame_data[g*CODE_W +: CODE_W];
  end

  assign last_slot   = (idx == IDX_LAST);
  assign boundary    = tick && last_slot;
  assign frame_ready = !pending && !rst;
  assign accept      = frame_valid && frame_ready;
  assign frame_done  = boundary && !rst;

`ifdef SEG_SCAN_LZB_EN
  logic blanking;

  // Blank leading plain zeros from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    promote_buf = pending_buf;
    blanking    = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if (blanking && (pending_buf[i] == CODE_ZERO)) begin
        promote_buf[i] = CODE_BLANK;
      end else begin
        blanking = 1'b0;
      end
    end
  end
`else
  // Codes are promoted exactly as accepted.
  always_comb begin
    promote_buf = pending_buf;
  end
`endif

  // Slot index, buffers and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= 1'b0;
      idx      <= '0;
      dig_code <= CODE_BLANK;
      an_n     <= '1;
      for (int i = 0; i < N_DIGITS; i++) begin
        pending_buf[i] <= CODE_BLANK;
        active_buf[i]  <= CODE_BLANK;
      end
    end else begin
      // Each tick lights the digit of the slot that just elapsed, so the
      // first tick after reset lights digit 0 and digit N-1 shows in the
      // boundary tick from the frame that was active before promotion.
      if (tick) begin
        idx      <= last_slot ? '0 : idx + IDX_W'(1);
        dig_code <= active_buf[idx];
        an_n     <= ~(ONE_HOT0 << idx);
      end
      // Promotion looks at the pending flag as it stood before this cycle,
      // so a frame accepted in the boundary cycle waits a whole frame.
      if (boundary && pending) begin
        active_buf <= promote_buf;
        pending    <= 1'b0;
      end
      if (accept) begin
        pending_buf <= frame_code;
        pending     <= 1'b1;
      end
    end
  end

endmodule : seg_scan_ctrl
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_ctrl
//  Purpose  : Self-checking bench for seg_scan_ctrl (N_DIGITS=4, TICK_DIV=4).
//             A cycle-count reference model predicts every displayed slot and
//             pushes it to a queue; a monitor pops it whenever the anode
//             select changes. frame_ready/frame_done are checked each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int W  = 5;
  localparam logic [W-1:0] BLANK = 5'b01111;

  typedef struct packed {
    logic [N-1:0] an;
    logic [W-1:0] code;
  } slot_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           frame_valid = 1'b0;
  logic           frame_ready;
  logic [N*W-1:0] frame_data = '0;
  logic [W-1:0]   dig_code;
  logic [N-1:0]   an_n;
  logic           frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  slot_t        exp_q[$];
  int           k = 0;
  logic         m_rst_seen = 1'b1;
  logic         m_pend = 1'b0;
  logic [W-1:0] m_active [N];
  logic [W-1:0] m_pbuf   [N];

  seg_scan_ctrl #(
    .N_DIGITS (N),
    .TICK_DIV (TD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .dig_code    (dig_code),
    .an_n        (an_n),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  // Leading-zero blanking as described: from the top digit down, plain zeros blank until any other code.
  function automatic void apply_lzb(ref logic [W-1:0] f [N]);
`ifdef SEG_SCAN_LZB_EN
    for (int i = N - 1; i >= 1; i--) begin
      if (f[i] != 5'b00000) break;
      f[i] = BLANK;
    end
`endif
  endfunction

  // Reference model: cycle k after reset release; slot s ends at tick k = TD*s + TD-1 and lights digit s mod N.
  initial begin
    int s;
    int d;
    logic acc;
    logic [N-1:0] one;
    one = 1;
    for (int i = 0; i < N; i++) begin
      m_active[i] = BLANK;
      m_pbuf[i]   = BLANK;
    end
    forever begin
      @(posedge clk);
      if (rst) begin
        m_rst_seen = 1'b1;
        k          = 0;
        m_pend     = 1'b0;
        exp_q.delete();
        for (int i = 0; i < N; i++) m_active[i] = BLANK;
      end else begin
        m_rst_seen = 1'b0;
        acc = frame_valid && !m_pend;
        if ((k % TD) == TD - 1) begin
          s = k / TD;
          d = s % N;
          exp_q.push_back('{an: ~(one << d), code: m_active[d]});
          if (d == N - 1 && m_pend) begin
            m_active = m_pbuf;
            apply_lzb(m_active);
            m_pend = 1'b0;
          end
        end
        if (acc) begin
          for (int i = 0; i < N; i++) m_pbuf[i] = frame_data[i*W +: W];
          m_pend = 1'b1;
        end
        k++;
      end
    end
  end

  // Monitor on the falling edge, away from the active edge.
  initial begin
    logic [N-1:0] prev_an;
    slot_t        e;
    logic         exp_ready;
    logic         exp_done;
    prev_an = '1;
    forever begin
      @(negedge clk);
      if (m_rst_seen) begin
        n_checks++;
        if (an_n !== '1 || dig_code !== BLANK) begin
          n_fail++;
          $display("FAIL reset_outputs an_n=%b dig_code=%h required an_n=%b dig_code=%h", an_n, dig_code, {N{1'b1}}, BLANK);
        end
      end else if (an_n !== prev_an) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_slot an_n=%b dig_code=%h required no change", an_n, dig_code);
        end else begin
          e = exp_q.pop_front();
          if (an_n !== e.an || dig_code !== e.code) begin
            n_fail++;
            $display("FAIL slot an_n=%b dig_code=%h required an_n=%b dig_code=%h", an_n, dig_code, e.an, e.code);
          end
        end
      end else if (exp_q.size() != 0) begin
        n_checks++;
        n_fail++;
        e = exp_q.pop_front();
        $display("FAIL missing_slot an_n=%b dig_code=%h required an_n=%b dig_code=%h", an_n, dig_code, e.an, e.code);
      end
      prev_an   = an_n;
      exp_ready = !rst && !m_pend;
      exp_done  = !rst && ((k % TD) == TD - 1) && (((k / TD) % N) == N - 1);
      n_checks++;
      if (frame_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL frame_ready got=%b required=%b (cycle %0d)", frame_ready, exp_ready, k);
      end
      n_checks++;
      if (frame_done !== exp_done) begin
        n_fail++;
        $display("FAIL frame_done got=%b required=%b (cycle %0d)", frame_done, exp_done, k);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Offer a frame once ready; noisy mode also waves valid with junk while not ready.
  task automatic send(input logic [N*W-1:0] d, input bit noisy);
    int budget;
    budget = 200;
    while (!frame_ready && budget > 0) begin
      frame_valid = noisy && ($urandom_range(0, 3) == 0);
      frame_data  = (N*W)'($urandom);
      step();
      budget--;
    end
    n_checks++;
    if (!frame_ready) begin
      n_fail++;
      $display("FAIL send_timeout frame_ready=%b required 1", frame_ready);
    end
    frame_valid = 1'b1;
    frame_data  = d;
    step();
    frame_valid = 1'b0;
    frame_data  = (N*W)'($urandom);
  endtask

  task automatic wait_an(input logic [N-1:0] target);
    int budget;
    budget = 200;
    while (an_n !== target && budget > 0) begin
      step();
      budget--;
    end
    n_checks++;
    if (an_n !== target) begin
      n_fail++;
      $display("FAIL wait_an_timeout an_n=%b required %b", an_n, target);
    end
  endtask

  function automatic logic [N*W-1:0] rand_frame();
    logic [N*W-1:0] f;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 3))
        0:       f[i*W +: W] = 5'h00;
        1:       f[i*W +: W] = 5'h10;
        default: f[i*W +: W] = W'($urandom);
      endcase
    end
    return f;
  endfunction

  initial begin
    int budget;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // Basic scan of {3,2,1,0}, watched for several frames.
    send({5'd3, 5'd2, 5'd1, 5'd0}, 1'b0);
    repeat (40) step();

    // Two frames back to back: the second must wait for a boundary.
    send({5'h19, 5'h08, 5'h17, 5'h06}, 1'b0);
    send({5'h05, 5'h14, 5'h03, 5'h12}, 1'b0);
    repeat (40) step();

    // Accept exactly in the frame_done cycle.
    budget = 100;
    while (!(frame_done && frame_ready) && budget > 0) begin
      step();
      budget--;
    end
    n_checks++;
    if (!(frame_done && frame_ready)) begin
      n_fail++;
      $display("FAIL collision_timeout frame_done=%b frame_ready=%b required 1 1", frame_done, frame_ready);
    end
    frame_valid = 1'b1;
    frame_data  = {5'h01, 5'h02, 5'h03, 5'h04};
    step();
    frame_valid = 1'b0;
    repeat (40) step();

    // Reset during slot 2 with a frame pending.
    wait_an(4'b1101);
    send({5'h09, 5'h09, 5'h09, 5'h09}, 1'b0);
    wait_an(4'b1011);
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (24) step();

    // Leading zeros with a decimal-point zero.
    send({5'h00, 5'h00, 5'h10, 5'h07}, 1'b0);
    repeat (40) step();

    // Randomized frames at random spacing.
    repeat (40) begin
      repeat ($urandom_range(0, 20)) step();
      send(rand_frame(), 1'b1);
    end
    repeat (40) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seg_scan_ctrl
`default_nettype wire
